// File: rtl/axi_wr_master.sv
// AXI4 write-burst initiator: user data staged in a 16-deep FWFT FIFO, then one AW, a W burst and one B per wr_trig.
// W streams from the FIFO head and stalls (never bubbles) when it runs dry; define WR_BRESP_CHK_EN for a sticky wr_err.
module axi_wr_master #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_trig,
  input  logic [7:0]              wr_len,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_data_en,
  output logic                    wr_full,
  output logic                    wr_ready,
  output logic                    wr_done,
  output logic                    axi_awvalid,
  input  logic                    axi_awready,
  output logic [ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]              axi_awlen,
  output logic                    axi_wvalid,
  input  logic                    axi_wready,
  output logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic [DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                    axi_wlast,
  input  logic                    axi_bvalid,
  output logic                    axi_bready,
  input  logic [1:0]              axi_bresp
`ifdef WR_BRESP_CHK_EN
  ,
  output logic                    wr_err
`endif
);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [7:0]            r_awlen, w_awlen_nxt;
  logic [7:0]            r_beat, w_beat_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  w_trig_acc;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_AW:0]      r_wptr, r_rptr;
  logic                  w_full, w_empty, w_push, w_pop, w_wlast;

  // Full is judged on pointers alone, so a push alongside a pop while full is still dropped.
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = wr_data_en && !w_full;
  assign w_pop   = axi_wvalid && axi_wready;
  assign w_wlast = axi_wvalid && (r_beat == r_awlen);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_awvalid <= 1'b0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_beat    <= '0;
      r_bready  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_awlen   <= w_awlen_nxt;
      r_beat    <= w_beat_nxt;
      r_bready  <= w_bready_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_awaddr_nxt  = r_awaddr;
    w_awlen_nxt   = r_awlen;
    w_beat_nxt    = r_beat;
    w_bready_nxt  = r_bready;
    w_trig_acc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wr_trig && (wr_len != 8'd0)) begin
          w_trig_acc    = 1'b1;
          w_awaddr_nxt  = wr_addr;
          w_awlen_nxt   = wr_len - 8'd1;
          w_awvalid_nxt = 1'b1;
          w_state_nxt   = S_AW;
        end
      end
      S_AW: begin
        if (axi_awready) begin
          w_awvalid_nxt = 1'b0;
          w_beat_nxt    = 8'd0;
          w_state_nxt   = S_W;
        end
      end
      S_W: begin
        if (w_pop) begin
          w_beat_nxt = r_beat + 8'd1;
          if (w_wlast) begin
            w_bready_nxt = 1'b1;
            w_state_nxt  = S_B;
          end
        end
      end
      S_B: begin
        if (axi_bvalid) begin
          w_bready_nxt = 1'b0;
          w_state_nxt  = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign wr_full     = w_full;
  assign wr_ready    = (r_state == S_IDLE);
  assign wr_done     = (r_state == S_DONE);
  assign axi_awvalid = r_awvalid;
  assign axi_awaddr  = r_awaddr;
  assign axi_awlen   = r_awlen;
  assign axi_wvalid  = (r_state == S_W) && !w_empty;
  assign axi_wdata   = r_mem[r_rptr[FIFO_AW-1:0]];
  assign axi_wstrb   = '1;
  assign axi_wlast   = w_wlast;
  assign axi_bready  = r_bready;

`ifdef WR_BRESP_CHK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (!rst_n)                                        r_err <= 1'b0;
    else if (w_trig_acc)                               r_err <= 1'b0;
    else if (axi_bvalid && r_bready && (axi_bresp != 2'b00)) r_err <= 1'b1;
  end
  assign wr_err = r_err;
`else
  logic w_unused;
  assign w_unused = ^{axi_bresp, w_trig_acc};
`endif

endmodule
